// File: rtl/fft_control_fsm.sv
// Top-level sequencer for the 512-point radix-2 FFT: load into bank 0, run 9 ping-pong
// butterfly levels, then stream the result out of bank 1 with a one-cycle RAM read latency.
module fft_control_fsm #(
    parameter int BFLY_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       load,
    output logic       processing,
    output logic       done,
    output logic [8:0] fft_level,
    output logic [8:0] butterfly_iter,
    output logic [8:0] load_address,
    output logic [8:0] out_address,
    output logic       we_0,
    output logic       we_1,
    output logic       rd_sel
);

    localparam int PH_W = (BFLY_LAT > 2) ? $clog2(BFLY_LAT) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BFLY_LAT - 1);
    localparam logic [8:0] LAST_IDX   = 9'd511;
    localparam logic [8:0] LAST_ITER  = 9'd255;
    localparam logic [8:0] LAST_LEVEL = 9'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PROC = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t          state;
    logic [PH_W-1:0] phase;
    logic            last_phase;

    assign last_phase = (phase == PH_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            phase          <= '0;
            fft_level      <= '0;
            butterfly_iter <= '0;
            load_address   <= '0;
            out_address    <= '0;
            out_valid      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    phase          <= '0;
                    fft_level      <= '0;
                    butterfly_iter <= '0;
                    load_address   <= '0;
                    out_address    <= '0;
                    out_valid      <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    if (in_valid) begin
                        if (load_address == LAST_IDX) begin
                            load_address <= '0;
                            phase        <= '0;
                            state        <= PROC;
                        end else begin
                            load_address <= load_address + 9'd1;
                        end
                    end
                end

                PROC: begin
                    // Counters advance on the edge closing the write cycle, so the
                    // write reuses the addresses the reads were issued with.
                    if (last_phase) begin
                        phase <= '0;
                        if (butterfly_iter == LAST_ITER) begin
                            butterfly_iter <= '0;
                            if (fft_level == LAST_LEVEL) begin
                                fft_level   <= '0;
                                out_address <= '0;
                                out_valid   <= 1'b0;
                                state       <= OUT;
                            end else begin
                                fft_level <= fft_level + 9'd1;
                            end
                        end else begin
                            butterfly_iter <= butterfly_iter + 9'd1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end

                OUT: begin
                    // out_valid rises one cycle after each address change (RAM latency).
                    if (out_valid) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (out_address == LAST_IDX) begin
                                out_address <= '0;
                                state       <= IDLE;
                            end else begin
                                out_address <= out_address + 9'd1;
                            end
                        end
                    end else begin
                        out_valid <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign load       = (state == LOAD);
    assign processing = (state == PROC);
    assign done       = (state == OUT);

    always_comb begin
        in_ready = 1'b0;
        we_0     = 1'b0;
        we_1     = 1'b0;
        rd_sel   = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                we_0     = in_valid;
            end
            PROC: begin
                // Even levels read bank 0 and write bank 1; odd levels the reverse.
                rd_sel = fft_level[0];
                if (last_phase) begin
                    we_0 = fft_level[0];
                    we_1 = ~fft_level[0];
                end
            end
            OUT: begin
                rd_sel = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fft_control_fsm.sv
// Directed bench for fft_control_fsm: reset, gapped/continuous load, processing schedule,
// output backpressure, reset mid-transform and ignored stray inputs.
module tb_fft_control_fsm;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       load;
    logic       processing;
    logic       done;
    logic [8:0] fft_level;
    logic [8:0] butterfly_iter;
    logic [8:0] load_address;
    logic [8:0] out_address;
    logic       we_0;
    logic       we_1;
    logic       rd_sel;

    int errors = 0;
    int checks = 0;

    fft_control_fsm #(.BFLY_LAT(2)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .load(load),
        .processing(processing),
        .done(done),
        .fft_level(fft_level),
        .butterfly_iter(butterfly_iter),
        .load_address(load_address),
        .out_address(out_address),
        .we_0(we_0),
        .we_1(we_1),
        .rd_sel(rd_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick(); #1;
        checks++;
        if ({load, processing, done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b required 000", {load, processing, done});
        end
        checks++;
        if ({in_ready, out_valid, we_0, we_1, rd_sel} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl: got %b required 00000", {in_ready, out_valid, we_0, we_1, rd_sel});
        end
        checks++;
        if ({fft_level, butterfly_iter, load_address, out_address} !== 36'd0) begin
            errors++; $display("FAIL reset_counters: got %h required 0", {fft_level, butterfly_iter, load_address, out_address});
        end
        reset = 1'b0; start = 1'b1;
        tick(); start = 1'b0; #1;
        checks++;
        if ({load, processing, done, in_ready} !== 4'b1001 || load_address !== 9'd0) begin
            errors++; $display("FAIL start_to_load: flags=%b addr=%0d required 1001 addr=0", {load, processing, done, in_ready}, load_address);
        end
        tick(); #1;
        checks++;
        if (load !== 1'b1 || load_address !== 9'd0 || we_0 !== 1'b0) begin
            errors++; $display("FAIL load_hold_no_valid: load=%b addr=%0d we_0=%b required 1,0,0", load, load_address, we_0);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(); start = 1'b0; #1;
        checks++;
        if (load !== 1'b1 || load_address !== 9'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL restart: load=%b addr=%0d in_ready=%b required 1,0,1", load, load_address, in_ready);
        end
    endtask

    task automatic run_load(input bit gapped);
        int k = 0;
        int accepted = 0;
        int bad = 0;
        int pulses = 0;
        while (accepted < 512 && k < 3000) begin
            in_valid = gapped ? (k % 2 == 0) : 1'b1;
            #1;
            if (load !== 1'b1 || in_ready !== 1'b1 || load_address !== 9'(accepted)
                || we_0 !== in_valid || we_1 !== 1'b0 || processing !== 1'b0)
                bad++;
            if (we_0 === 1'b1) pulses++;
            if (in_valid) accepted++;
            k++;
            tick();
        end
        in_valid = 1'b0; #1;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL load_sequence: bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (k != (gapped ? 1023 : 512) || pulses != 512) begin
            errors++; $display("FAIL load_length: cycles=%0d we0_pulses=%0d required %0d and 512", k, pulses, gapped ? 1023 : 512);
        end
        checks++;
        if (processing !== 1'b1 || load !== 1'b0 || load_address !== 9'd0 || fft_level !== 9'd0 || butterfly_iter !== 9'd0) begin
            errors++; $display("FAIL proc_entry: proc=%b load=%b addr=%0d lvl=%0d it=%0d required 1,0,0,0,0",
                               processing, load, load_address, fft_level, butterfly_iter);
        end
    endtask

    task automatic run_processing(input bit stray);
        int c = 0;
        int bad = 0;
        int n0 = 0;
        int n1 = 0;
        int lastl = -1;
        int lasti = -1;
        int exp_lv, exp_it, exp_ph;
        while (processing === 1'b1 && c < 6000) begin
            start = stray && (c == 1001);
            #1;
            exp_lv = c / 512;
            exp_it = (c / 2) % 256;
            exp_ph = c % 2;
            if (fft_level !== 9'(exp_lv) || butterfly_iter !== 9'(exp_it)
                || rd_sel !== fft_level[0]
                || we_1 !== ((exp_ph == 1) && (exp_lv % 2 == 0))
                || we_0 !== ((exp_ph == 1) && (exp_lv % 2 == 1))
                || load !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
                bad++;
            if (we_0 === 1'b1) n0++;
            if (we_1 === 1'b1) n1++;
            if (we_0 === 1'b1 || we_1 === 1'b1) begin
                lastl = int'(fft_level);
                lasti = int'(butterfly_iter);
            end
            c++;
            tick();
        end
        start = 1'b0; #1;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL proc_schedule: bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (c != 4608) begin
            errors++; $display("FAIL proc_length: cycles=%0d required 4608", c);
        end
        checks++;
        if (n1 != 1280 || n0 != 1024) begin
            errors++; $display("FAIL proc_writes: we_1=%0d we_0=%0d required 1280 and 1024", n1, n0);
        end
        checks++;
        if (lastl != 8 || lasti != 255) begin
            errors++; $display("FAIL last_write: level=%0d iter=%0d required 8 and 255", lastl, lasti);
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || rd_sel !== 1'b1 || fft_level !== 9'd0 || butterfly_iter !== 9'd0 || out_address !== 9'd0) begin
            errors++; $display("FAIL out_entry: done=%b ov=%b rd=%b lvl=%0d it=%0d oa=%0d required 1,0,1,0,0,0",
                               done, out_valid, rd_sel, fft_level, butterfly_iter, out_address);
        end
    endtask

    task automatic run_output(input bit bp, input bit stray);
        int c = 0;
        int bad = 0;
        int hs = 0;
        bit exp_ov = 1'b0;
        int exp_addr = 0;
        if (bp) begin
            for (int i = 0; i < 11; i++) begin
                out_ready = 1'b0; in_valid = stray; #1;
                if (out_valid !== (i > 0) || out_address !== 9'd0 || we_0 !== 1'b0 || we_1 !== 1'b0 || done !== 1'b1)
                    bad++;
                tick();
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL out_backpressure: bad_cycles=%0d required 0", bad);
            end
            bad = 0;
            exp_ov = 1'b1;
        end
        while (done === 1'b1 && c < 3000) begin
            out_ready = 1'b1; in_valid = stray; #1;
            if (out_valid !== exp_ov || out_address !== 9'(exp_addr) || we_0 !== 1'b0 || we_1 !== 1'b0
                || rd_sel !== 1'b1 || load !== 1'b0 || in_ready !== 1'b0)
                bad++;
            if (exp_ov) begin
                hs++;
                if (exp_addr != 511) exp_addr++;
                exp_ov = 1'b0;
            end else begin
                exp_ov = 1'b1;
            end
            c++;
            tick();
        end
        #1;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL out_stream: bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (hs != 512 || c != (bp ? 1023 : 1024)) begin
            errors++; $display("FAIL out_length: handshakes=%0d cycles=%0d required 512 and %0d", hs, c, bp ? 1023 : 1024);
        end
        checks++;
        if ({load, processing, done, out_valid, we_0, we_1, in_ready} !== 7'd0 || out_address !== 9'd0) begin
            errors++; $display("FAIL out_to_idle: flags=%b oa=%0d required 0000000 oa=0",
                               {load, processing, done, out_valid, we_0, we_1, in_ready}, out_address);
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_proc();
        int c = 0;
        do_start();
        run_load(1'b0);
        while (!(fft_level === 9'd4 && butterfly_iter === 9'd100) && c < 6000) begin
            tick(); #1;
            c++;
        end
        checks++;
        if (processing !== 1'b1 || fft_level !== 9'd4 || butterfly_iter !== 9'd100) begin
            errors++; $display("FAIL reach_l4_i100: proc=%b lvl=%0d it=%0d required 1,4,100", processing, fft_level, butterfly_iter);
        end
        reset = 1'b1;
        tick(); #1;
        checks++;
        if ({load, processing, done, in_ready, out_valid, we_0, we_1, rd_sel} !== 8'd0
            || {fft_level, butterfly_iter, load_address, out_address} !== 36'd0) begin
            errors++; $display("FAIL reset_mid_proc: flags=%b counters=%h required 0 and 0",
                               {load, processing, done, in_ready, out_valid, we_0, we_1, rd_sel},
                               {fft_level, butterfly_iter, load_address, out_address});
        end
        reset = 1'b0;
        do_start();
        run_load(1'b0);
        run_processing(1'b0);
        run_output(1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        run_load(1'b1);
        run_processing(1'b1);
        run_output(1'b1, 1'b1);
        test_reset_mid_proc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
